// File: rtl/button_seq_lock_pkg.sv
// button_seq_lock_pkg: shared state encoding, LED polarity and sizing helper for the code lock.
package button_seq_lock_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COLLECT  = 3'd1,
      UNLOCKED = 3'd2,
      ERROR    = 3'd3,
      LOCKOUT  = 3'd4
   } state_e;
   localparam logic LED_ON  = 1'b0;
   localparam logic LED_OFF = 1'b1;
   function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/button_seq_lock_debounce.sv
// button_debounce: 2-flop synchroniser plus stability counter for one active-low pad;
// press pulses for one cycle on each accepted 1->0 edge.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 270000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level_n,
   output logic press
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          settle;
   assign settle = (sync_q[1] != level_n) && (cnt_q == CW'(DEBOUNCE_CYC - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_n <= 1'b1;
         press   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_n};
         cnt_q  <= (sync_q[1] == level_n || settle) ? '0 : cnt_q + 1'b1;
         if (settle) level_n <= sync_q[1];
         press <= settle & ~sync_q[1];
      end
endmodule

// File: rtl/button_seq_lock.sv
// button_seq_lock: two-button code-entry lock with retry limit, error flash and timed lockout.
module button_seq_lock
   import button_seq_lock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 270000,
   parameter int unsigned SEQ_LEN      = 4,
   parameter logic [7:0]  SEQ_CODE     = 8'b0110,
   parameter int unsigned TIMEOUT_CYC  = 54000000,
   parameter int unsigned ERR_CYC      = 13500000,
   parameter int unsigned MAX_FAILS    = 3,
   parameter int unsigned LOCKOUT_CYC  = 270000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       button3,
   input  logic       button4,
   output logic       led,
   output logic       led_err,
   output logic       locked_out,
   output logic [3:0] fail_cnt
);
   localparam int unsigned TW = $clog2(max3(TIMEOUT_CYC, ERR_CYC, LOCKOUT_CYC) + 1);
   localparam int unsigned IW = $clog2(SEQ_LEN) + 1;
   state_e        state_q;
   logic [TW-1:0] tmr_q;
   logic [IW-1:0] idx_q, cur_idx;
   logic          mis_q, led_q, err_q, lo_q;
   logic [3:0]    fail_q;
   logic          press3, press4, level3_unused, level4_unused;
   logic          press, in_col, want4, cur_mis, last, expire, fail, pass, advance, to_lock;
   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb3 (
      .clk(clk), .rst_n(rst_n), .btn_n(button3), .level_n(level3_unused), .press(press3)
   );
   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb4 (
      .clk(clk), .rst_n(rst_n), .btn_n(button4), .level_n(level4_unused), .press(press4)
   );
   // A press in IDLE is scored as index 0 with a clean mismatch flag.
   assign press   = press3 | press4;
   assign in_col  = state_q == COLLECT;
   assign cur_idx = in_col ? idx_q : '0;
   assign want4   = |(SEQ_CODE & (8'd1 << cur_idx));
   assign cur_mis = (in_col & mis_q) | (press3 & press4) | (press4 ^ want4);
   assign last    = cur_idx == IW'(SEQ_LEN - 1);
   assign expire  = in_col && tmr_q == TW'(TIMEOUT_CYC);
   assign fail    = expire | (press & last & cur_mis);
   assign pass    = ~expire & press & last & ~cur_mis;
   assign advance = ~expire & press & ~last;
   assign to_lock = fail_q + 4'd1 == 4'(MAX_FAILS);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         fail_q  <= 4'd0;
         led_q   <= LED_OFF;
         err_q   <= LED_OFF;
         lo_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, COLLECT:
               if (fail) begin
                  state_q <= to_lock ? LOCKOUT : ERROR;
                  fail_q  <= (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
                  err_q   <= LED_ON;
                  lo_q    <= to_lock;
                  tmr_q   <= '0;
               end else if (pass) begin
                  state_q <= UNLOCKED;
                  fail_q  <= 4'd0;
                  led_q   <= LED_ON;
                  tmr_q   <= '0;
               end else if (advance) begin
                  state_q <= COLLECT;
                  idx_q   <= cur_idx + 1'b1;
                  mis_q   <= cur_mis;
                  tmr_q   <= '0;
               end else if (in_col) tmr_q <= tmr_q + 1'b1;
            UNLOCKED:
               if (press) begin
                  state_q <= IDLE;
                  led_q   <= LED_OFF;
               end
            ERROR:
               if (tmr_q == TW'(ERR_CYC - 1)) begin
                  state_q <= IDLE;
                  err_q   <= LED_OFF;
                  tmr_q   <= '0;
               end else tmr_q <= tmr_q + 1'b1;
            LOCKOUT:
               if (tmr_q == TW'(LOCKOUT_CYC - 1)) begin
                  state_q <= IDLE;
                  err_q   <= LED_OFF;
                  lo_q    <= 1'b0;
                  fail_q  <= 4'd0;
                  tmr_q   <= '0;
               end else tmr_q <= tmr_q + 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   assign led        = led_q;
   assign led_err    = err_q;
   assign locked_out = lo_q;
   assign fail_cnt   = fail_q;
endmodule
